// File: rtl/shift_in_frame_pkg.sv
// shift_in_frame_pkg: shared FSM state encoding and default frame geometry.
package shift_in_frame_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } state_e;
  localparam int DEF_WIDTH  = 64;
  localparam int DEF_CWIDTH = 6;
endpackage

// File: rtl/shift_in_frame_even_parity_acc.sv
// even_parity_acc: running XOR of the data bits of a frame, cleared on start.
module even_parity_acc (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic par_o
);
  always_ff @(posedge clk or posedge reset)
    if (reset) par_o <= 1'b0;
    else if (clr_i) par_o <= 1'b0;
    else if (en_i) par_o <= par_o ^ bit_i;
endmodule

// File: rtl/shift_in_frame.sv
// shift_in_frame: LSB-first serial-to-parallel frame receiver with a one-word output register.
// Optional trailing even-parity bit enabled by SHIFT_IN_FRAME_PARITY_EN.
module shift_in_frame
  import shift_in_frame_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int CWIDTH = DEF_CWIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             enable,
  input  logic             sin,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow,
  output logic             parity_err
);
  if (2**CWIDTH != WIDTH) begin : g_bad_geometry
    $error("shift_in_frame: 2**CWIDTH must equal WIDTH");
  end
  state_e            state_q;
  logic [CWIDTH-1:0] idx_q;
  logic [WIDTH-1:0]  sh_q;
  logic              perr_c;
`ifdef SHIFT_IN_FRAME_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
  logic acc, par_q;
  even_parity_acc u_par (
    .clk   (clk),
    .reset (reset),
    .clr_i (start),
    .en_i  (state_q == SHIFT && enable),
    .bit_i (sin),
    .par_o (acc)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) par_q <= 1'b0;
    else if (state_q == PARITY && enable) par_q <= sin;
  assign perr_c = acc ^ par_q;
`else
  localparam state_e AFTER_DATA = COMMIT;
  assign perr_c = 1'b0;
`endif
  assign busy = state_q != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      sh_q       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      overflow   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      // start wins in every state: aborts any frame in flight without touching out_*
      if (start) begin
        state_q <= SHIFT;
        idx_q   <= '0;
        sh_q    <= '0;
      end else
        case (state_q)
          SHIFT:
            if (enable) begin
              sh_q[idx_q] <= sin;
              idx_q       <= idx_q + 1'b1;
              if (&idx_q) state_q <= AFTER_DATA;
            end
          PARITY:
            if (enable) state_q <= COMMIT;
          COMMIT: begin
            state_q <= IDLE;
            if (!out_valid || out_ready) begin
              out_data   <= sh_q;
              parity_err <= perr_c;
              out_valid  <= 1'b1;
            end else overflow <= 1'b1;
          end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_shift_in_frame.sv
// tb_shift_in_frame: table-driven frame vectors plus directed overflow/abort/reset sequences.
module tb_shift_in_frame;
  logic        clk = 1'b0;
  logic        reset, start, enable, sin, out_ready;
  logic [63:0] out_data;
  logic        out_valid, busy, overflow, parity_err;
  int          n_chk = 0;
  int          n_fail = 0;
`ifdef SHIFT_IN_FRAME_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam logic [63:0] W_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W_F = 64'hFFFF_FFFF_FFFF_FFFF;
  typedef struct {
    string       name;
    logic [63:0] data;
    bit          toggle;
    bit          pbit;
    logic [63:0] exp_data;
    bit          exp_perr;
  } vec_t;
  vec_t vecs[5];
  always #5 clk = ~clk;
  shift_in_frame dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .enable     (enable),
    .sin        (sin),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .overflow   (overflow),
    .parity_err (parity_err)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic bits(input logic [63:0] d, input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle && i > 0) begin
        enable = 1'b0;
        step();
      end
      enable = 1'b1;
      sin    = d[i];
      step();
    end
    enable = 1'b0;
    sin    = 1'b0;
  endtask
  task automatic frame(input logic [63:0] d, input bit toggle, input bit pbit);
    start = 1'b1;
    step();
    start = 1'b0;
    bits(d, 64, toggle);
    if (PB == 1) begin
      if (toggle) step();
      enable = 1'b1;
      sin    = pbit;
      step();
      enable = 1'b0;
      sin    = 1'b0;
    end
  endtask
  task automatic run_vec(input vec_t v);
    frame(v.data, v.toggle, v.pbit);
    chk({v.name, " valid_early"}, 64'(out_valid), 64'd0);
    step();
    chk({v.name, " valid_rise"}, 64'(out_valid), 64'd1);
    chk({v.name, " data"}, out_data, v.exp_data);
    chk({v.name, " perr"}, 64'(parity_err), 64'(v.exp_perr));
    chk({v.name, " overflow"}, 64'(overflow), 64'd0);
    chk({v.name, " busy"}, 64'(busy), 64'd0);
    step();
    chk({v.name, " valid_drop"}, 64'(out_valid), 64'd0);
  endtask
  initial begin
    vecs[0] = '{"word_a", W_A, 1'b0, ^W_A, W_A, 1'b0};
    vecs[1] = '{"word_a_toggle", W_A, 1'b1, ^W_A, W_A, 1'b0};
    vecs[2] = '{"ones", W_F, 1'b0, 1'b0, W_F, 1'b0};
    vecs[3] = '{"zeros", 64'h0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[4] = '{"ends_toggle", 64'h8000_0000_0000_0001, 1'b1, 1'b0, 64'h8000_0000_0000_0001, 1'b0};
    reset = 1'b1; start = 1'b0; enable = 1'b0; sin = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst data", out_data, 64'h0);
    chk("rst valid", 64'(out_valid), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst overflow", 64'(overflow), 64'd0);
    chk("rst perr", 64'(parity_err), 64'd0);
    step();
    reset = 1'b0;
    step();
    // enable/sin with no start must not start a frame
    bits(W_F, 8, 1'b0);
    chk("idle busy", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    // Back-to-back frames with consumer stalled: second frame is dropped.
    out_ready = 1'b0;
    frame(W_A, 1'b0, ^W_A);
    step();
    chk("ovf first valid", 64'(out_valid), 64'd1);
    frame(W_F, 1'b0, 1'b0);
    step();
    chk("ovf flag", 64'(overflow), 64'd1);
    chk("ovf data held", out_data, W_A);
    chk("ovf valid held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("ovf valid drop", 64'(out_valid), 64'd0);
    chk("ovf sticky", 64'(overflow), 64'd1);
    // Restart after 20 bits: partial frame discarded.
    start = 1'b1;
    step();
    start = 1'b0;
    bits(64'hA5A5_A5A5_A5A5_A5A5, 20, 1'b0);
    chk("abort busy", 64'(busy), 64'd1);
    chk("abort no valid", 64'(out_valid), 64'd0);
    frame(W_F, 1'b0, 1'b0);
    chk("abort valid_early", 64'(out_valid), 64'd0);
    step();
    chk("abort valid", 64'(out_valid), 64'd1);
    chk("abort data", out_data, W_F);
    step();
    chk("abort valid_drop", 64'(out_valid), 64'd0);
    // Reset 40 bits into a frame clears everything immediately.
    start = 1'b1;
    step();
    start = 1'b0;
    bits(W_A, 40, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid rst data", out_data, 64'h0);
    chk("mid rst valid", 64'(out_valid), 64'd0);
    chk("mid rst busy", 64'(busy), 64'd0);
    chk("mid rst overflow", 64'(overflow), 64'd0);
    chk("mid rst perr", 64'(parity_err), 64'd0);
    #2;
    reset = 1'b0;
    step();
    bits(W_A, 64, 1'b0);
    step();
    step();
    chk("post rst valid", 64'(out_valid), 64'd0);
    chk("post rst busy", 64'(busy), 64'd0);
    chk("post rst data", out_data, 64'h0);
`ifdef SHIFT_IN_FRAME_PARITY_EN
    run_vec('{"par_bad", 64'h1, 1'b0, 1'b0, 64'h1, 1'b1});
    run_vec('{"par_good", 64'h1, 1'b0, 1'b1, 64'h1, 1'b0});
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_in_frame.md
SHIFT_IN_FRAME -- requirements
Module: shift_in_frame

Interface
REQ-001 Parameter WIDTH, default 64, SHALL be the number of data bits per frame (8 bytes).
REQ-002 Parameter CWIDTH, default 6, SHALL be the bit-index counter width; the design SHALL require 2**CWIDTH == WIDTH.
REQ-003 clk  input  1  SHALL be the single clock; all state changes SHALL occur on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle synchronous pulse that begins a frame.
REQ-006 enable  input  1  SHALL be a bit strobe; sin is sampled only on cycles where enable=1.
REQ-007 sin  input  1  SHALL be the serial data bit, LSB first (bit 0 first), matching the team's parallel-to-serial shifter.
REQ-008 out_data  output  WIDTH  SHALL be the assembled word held in the output register.
REQ-009 out_valid  output  1  SHALL be high while out_data holds an unconsumed word.
REQ-010 out_ready  input  1  SHALL be the consumer acceptance; a transfer SHALL occur when out_valid && out_ready.
REQ-011 busy  output  1  SHALL be high in any state other than IDLE.
REQ-012 overflow  output  1  SHALL be a sticky flag set when a completed frame is dropped.
REQ-013 parity_err  output  1  SHALL accompany out_data (meaningful only with SHIFT_IN_FRAME_PARITY_EN).

Function
REQ-014 States SHALL be IDLE, SHIFT, PARITY, COMMIT.
REQ-015 IDLE: start=1 -> SHIFT with index cleared to 0 and shift register cleared; enable and sin SHALL be ignored in IDLE.
REQ-016 SHIFT: each enable=1 cycle SHALL write sin into bit[index] and increment index; enable=0 SHALL hold all state.
REQ-017 SHIFT: when bit WIDTH-1 is captured (index all-ones), next state SHALL be PARITY if the parity feature is compiled in, else COMMIT; index SHALL wrap to 0.
REQ-018 COMMIT SHALL last exactly one cycle, then return to IDLE.
REQ-019 COMMIT with out_valid=0, or with out_valid=1 and out_ready=1 in the same cycle, SHALL load out_data/parity_err and set out_valid on the next edge.
REQ-020 COMMIT with out_valid=1 and out_ready=0 SHALL drop the new word, keep the old word, and set overflow.
REQ-021 out_valid SHALL clear on the edge after out_valid && out_ready unless a COMMIT load occurs on that edge.
REQ-022 Latency: out_valid SHALL rise 2 cycles after the enable cycle sampling the last data bit (no parity) or the parity bit (with parity).
REQ-023 start asserted while busy=1 SHALL abort the frame in progress and restart at index 0; partial data SHALL be discarded and out_* unaffected.
REQ-024 overflow SHALL clear only on reset.

Reset
REQ-025 reset=1 SHALL immediately force state IDLE, index 0, shift register 0, out_data 0, out_valid 0, busy 0, overflow 0, parity_err 0.
REQ-026 reset asserted mid-frame SHALL discard the frame with no out_valid pulse.

Configuration
REQ-027 With macro SHIFT_IN_FRAME_PARITY_EN defined, the PARITY state SHALL sample one extra bit on the next enable cycle, and parity_err SHALL be 1 if the XOR of the WIDTH data bits and the parity bit is 1 (even parity).
REQ-028 Without SHIFT_IN_FRAME_PARITY_EN, the PARITY state SHALL be unreachable, no extra bit SHALL be consumed, and parity_err SHALL be constant 0.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE=0, SHIFT=1, PARITY=2, COMMIT=3) and the default WIDTH/CWIDTH constants.
REQ-030 A sub-module even_parity_acc SHALL hold the running XOR (clear on start, update on each SHIFT enable); it SHALL be instantiated only when SHIFT_IN_FRAME_PARITY_EN is defined.

Verification
REQ-031 start, then 64 enable cycles carrying 64'h0123_4567_89AB_CDEF LSB first, out_ready=1 -> out_data=64'h0123_4567_89AB_CDEF, out_valid for exactly one cycle, overflow=0.
REQ-032 Same frame with enable toggling 1/0 each cycle -> identical out_data; out_valid rises 2 cycles after the 64th enable.
REQ-033 Two frames back to back with out_ready=0 -> first word held, overflow=1, out_data unchanged; then out_ready=1 -> out_valid drops next cycle.
REQ-034 start again after 20 bits, then a full frame of 64'hFFFF_FFFF_FFFF_FFFF -> out_data=64'hFFFF_FFFF_FFFF_FFFF, no word emitted for the aborted frame.
REQ-035 reset pulse after 40 bits -> all outputs 0 immediately; no out_valid until a new start.
REQ-036 With SHIFT_IN_FRAME_PARITY_EN: data 64'h1 followed by parity bit 0 -> parity_err=1; followed by parity bit 1 -> parity_err=0.
